// File: rtl/uart_pkg.sv
// Shared UART definitions: oversampling ratio, baud select type, baud table,
// divisor helper and receiver state encoding. Used by rx_uart and uart_baud_tick.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 16;

    typedef logic [2:0] baud_sel_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int BAUD_TABLE [8] = '{1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200};

    // Clocks per oversampling tick, rounded to nearest.
    function automatic logic [DIV_W-1:0] div_for(input int clk_hz, input baud_sel_t sel);
        int ticks_hz;
        ticks_hz = BAUD_TABLE[sel] * OVERSAMPLE;
        return DIV_W'((clk_hz + ticks_hz / 2) / ticks_hz);
    endfunction

endpackage

// File: rtl/rx_uart_if.sv
// Receiver-side bundle: serial line and configuration in, byte and status out.
interface rx_uart_if;
    import uart_pkg::*;

    logic       RxIn;
    baud_sel_t  BaudSel;
    logic       ParEn;
    logic       Par;
    logic [7:0] DataOut;
    logic       Valid;
    logic       ParErr;
    logic       FrameErr;
    logic       Busy;

    modport slave  (input  RxIn, BaudSel, ParEn, Par,
                    output DataOut, Valid, ParErr, FrameErr, Busy);
    modport master (output RxIn, BaudSel, ParEn, Par,
                    input  DataOut, Valid, ParErr, FrameErr, Busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider: one-clock tick every div clocks; restart realigns
// the phase so the first tick lands div clocks after the restart cycle.
module uart_baud_tick
    import uart_pkg::*;
(
    input  logic             Clock,
    input  logic             Rst,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_reg;

    assign tick = !restart && (cnt_reg >= div - DIV_W'(1));

    // Free-running count, cleared on restart and on every tick.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            cnt_reg <= '0;
        end else if (restart || tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + DIV_W'(1);
        end
    end

endmodule

// File: rtl/rx_uart.sv
// UART receiver: 16x oversampled, 8N1 or 8 data + parity + 1 stop.
// Optional build macro RX_MAJORITY_EN: each bit decision is a 2-of-3 vote of
// three consecutive ticks around the nominal sample, decided one tick later.
module rx_uart
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int OVERSAMPLE = 16
)(
    input  logic      Clock,
    input  logic      Rst,
    rx_uart_if.slave  bus
);

    localparam logic [3:0] TC_LAST  = 4'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [3:0] START_TC = 4'(OVERSAMPLE / 2);
`else
    localparam logic [3:0] START_TC = 4'(OVERSAMPLE / 2 - 1);
`endif

    logic sync_reg, rxs, rxs_prev;
    logic fall, tick, restart, bit_val;

    rx_state_t        state_reg, state_next;
    logic [3:0]       tc_reg, tc_next;
    logic [2:0]       idx_reg, idx_next;
    logic [7:0]       shift_reg, shift_next;
    baud_sel_t        sel_reg, sel_next;
    logic             par_en_reg, par_en_next;
    logic             par_reg, par_next;
    logic             perr_reg, perr_next;
    logic [7:0]       data_reg, data_next;
    logic             par_err_reg, par_err_next;
    logic             frame_err_reg, frame_err_next;
    logic             valid_reg, valid_next;
    logic [DIV_W-1:0] div_tab [8];

    // Line synchroniser and previous-value flop for edge detection.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            sync_reg <= 1'b1;
            rxs      <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            sync_reg <= bus.RxIn;
            rxs      <= sync_reg;
            rxs_prev <= rxs;
        end
    end

    assign fall    = rxs_prev && !rxs;
    assign restart = (state_reg == IDLE) && fall;

    // Divisors are elaboration-time constants, selected by the latched rate.
    for (genvar gi = 0; gi < 8; gi++) begin : g_div
        assign div_tab[gi] = div_for(CLK_HZ, baud_sel_t'(gi));
    end

    uart_baud_tick u_tick (
        .Clock   (Clock),
        .Rst     (Rst),
        .restart (restart),
        .div     (div_tab[sel_reg]),
        .tick    (tick)
    );

`ifdef RX_MAJORITY_EN
    logic [1:0] hist_reg;

    // Line value at the two previous ticks, for the vote.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            hist_reg <= 2'b11;
        end else if (tick) begin
            hist_reg <= {hist_reg[0], rxs};
        end
    end

    assign bit_val = (hist_reg[1] & hist_reg[0]) | (hist_reg[1] & rxs) | (hist_reg[0] & rxs);
`else
    assign bit_val = rxs;
`endif

    // Next-state and datapath decisions; everything holds unless a tick acts.
    always_comb begin
        state_next     = state_reg;
        tc_next        = tc_reg;
        idx_next       = idx_reg;
        shift_next     = shift_reg;
        sel_next       = sel_reg;
        par_en_next    = par_en_reg;
        par_next       = par_reg;
        perr_next      = perr_reg;
        data_next      = data_reg;
        par_err_next   = par_err_reg;
        frame_err_next = frame_err_reg;
        valid_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next  = START;
                    tc_next     = '0;
                    idx_next    = '0;
                    perr_next   = 1'b0;
                    sel_next    = bus.BaudSel;
                    par_en_next = bus.ParEn;
                    par_next    = bus.Par;
                end
            end
            START: begin
                if (tick) begin
                    if (tc_reg == START_TC) begin
                        tc_next    = '0;
                        state_next = bit_val ? IDLE : DATA;
                    end else begin
                        tc_next = tc_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tc_reg == TC_LAST) begin
                        tc_next    = '0;
                        shift_next = {bit_val, shift_reg[7:1]};
                        idx_next   = idx_reg + 3'd1;
                        if (idx_reg == 3'd7) begin
                            state_next = par_en_reg ? PARITY : STOP;
                        end
                    end else begin
                        tc_next = tc_reg + 4'd1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    if (tc_reg == TC_LAST) begin
                        tc_next    = '0;
                        perr_next  = ((^shift_reg) ^ bit_val) != par_reg;
                        state_next = STOP;
                    end else begin
                        tc_next = tc_reg + 4'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (tc_reg == TC_LAST) begin
                        tc_next        = '0;
                        data_next      = shift_reg;
                        par_err_next   = perr_reg;
                        frame_err_next = !bit_val;
                        valid_next     = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        tc_next = tc_reg + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, counters, latched configuration and output registers.
    always_ff @(posedge Clock or negedge Rst) begin
        if (!Rst) begin
            state_reg     <= IDLE;
            tc_reg        <= '0;
            idx_reg       <= '0;
            shift_reg     <= '0;
            sel_reg       <= '0;
            par_en_reg    <= 1'b0;
            par_reg       <= 1'b0;
            perr_reg      <= 1'b0;
            data_reg      <= '0;
            par_err_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            valid_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tc_reg        <= tc_next;
            idx_reg       <= idx_next;
            shift_reg     <= shift_next;
            sel_reg       <= sel_next;
            par_en_reg    <= par_en_next;
            par_reg       <= par_next;
            perr_reg      <= perr_next;
            data_reg      <= data_next;
            par_err_reg   <= par_err_next;
            frame_err_reg <= frame_err_next;
            valid_reg     <= valid_next;
        end
    end

    assign bus.DataOut  = data_reg;
    assign bus.Valid    = valid_reg;
    assign bus.ParErr   = par_err_reg;
    assign bus.FrameErr = frame_err_reg;
    assign bus.Busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_rx_uart.sv
// Testbench for rx_uart at 50 MHz, 115200 baud (432 clocks per bit).
// Frames are built from bit lists; expected byte/status come from frame contents.
module tb_rx_uart;
    import uart_pkg::*;

    localparam int CLK_HZ = 50000000;
    localparam int BIT    = 432;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic Clock = 1'b0;
    logic Rst   = 1'b0;
    always #10 Clock = ~Clock;

    rx_uart_if bus();

    rx_uart #(.CLK_HZ(CLK_HZ)) dut (
        .Clock (Clock),
        .Rst   (Rst),
        .bus   (bus.slave)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_valid  = 0;
    int   n_sent   = 0;
    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every Valid pops one expected frame.
    always @(negedge Clock) begin
        if (Rst && bus.Valid) begin
            exp_t e;
            n_valid++;
            check("valid_one_cycle", prev_valid, 0);
            check("busy_at_valid", bus.Busy, 0);
            if (exp_q.size() == 0) begin
                check("valid_has_frame", 32'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                $display("rx byte=%02h par_err=%0b frame_err=%0b (exp %02h %0b %0b)",
                         bus.DataOut, bus.ParErr, bus.FrameErr, e.d, e.pe, e.fe);
                check("data", bus.DataOut, e.d);
                check("par_err", bus.ParErr, e.pe);
                check("frame_err", bus.FrameErr, e.fe);
            end
        end
        prev_valid = bus.Valid;
    end

    task automatic drive_bit(input logic v, input bit glitch);
        for (int c = 0; c < BIT; c++) begin
            bus.RxIn = (glitch && c == BIT / 2) ? ~v : v;
            @(negedge Clock);
        end
    endtask

    // Send one frame; the expected result is queued when expect_it is set.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic p,
                              input logic pbit, input logic stop, input int gap,
                              input bit expect_it, input bit scramble, input int glitch_bit);
        exp_t e;
        bus.BaudSel = 3'd7;
        bus.ParEn   = pen;
        bus.Par     = p;
        if (expect_it) begin
            e.d  = d;
            e.pe = pen ? ((($countones(d) + int'(pbit)) % 2 == 1) != p) : 1'b0;
            e.fe = !stop;
            exp_q.push_back(e);
            n_sent++;
        end
        drive_bit(1'b0, 1'b0);
        if (scramble) begin
            bus.BaudSel = 3'($urandom_range(0, 6));
            bus.ParEn   = 1'($urandom);
            bus.Par     = 1'($urandom);
        end
        for (int i = 0; i < 8; i++) drive_bit(d[i], glitch_bit == i);
        if (pen) drive_bit(pbit, 1'b0);
        drive_bit(stop, 1'b0);
        bus.RxIn = 1'b1;
        repeat (gap) @(negedge Clock);
    endtask

    initial begin
        bus.RxIn    = 1'b1;
        bus.BaudSel = 3'd7;
        bus.ParEn   = 1'b0;
        bus.Par     = 1'b0;
        repeat (5) @(negedge Clock);
        check("rst_data", bus.DataOut, 0);
        check("rst_valid", bus.Valid, 0);
        check("rst_par_err", bus.ParErr, 0);
        check("rst_frame_err", bus.FrameErr, 0);
        check("rst_busy", bus.Busy, 0);
        Rst = 1'b1;
        repeat (20) @(negedge Clock);

        send_frame(8'hA5, 0, 0, 0, 1, 20, 1, 0, -1);
        check("idle_busy", bus.Busy, 0);
        send_frame(8'h3C, 1, 0, 0, 1, 20, 1, 0, -1);
        send_frame(8'h3C, 1, 0, 1, 1, 20, 1, 0, -1);
        send_frame(8'h55, 0, 0, 0, 0, 20, 1, 0, -1);
        send_frame(8'h0F, 0, 0, 0, 1, 20, 1, 0, -1);

        // False start: short low pulse.
        bus.RxIn = 1'b0;
        repeat (50) @(negedge Clock);
        check("busy_false_start", bus.Busy, 1);
        repeat (50) @(negedge Clock);
        bus.RxIn = 1'b1;
        repeat (300) @(negedge Clock);
        check("busy_after_false_start", bus.Busy, 0);
        check("data_hold_false_start", bus.DataOut, 8'h0F);
        send_frame(8'h81, 0, 0, 0, 1, 20, 1, 0, -1);

        // Reset during data bit 4; the aborted frame must not be reported.
        fork
            send_frame(8'h81, 0, 0, 0, 1, 20, 0, 0, -1);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge Clock);
                check("busy_mid_frame", bus.Busy, 1);
                Rst = 1'b0;
                #1;
                check("mid_rst_data", bus.DataOut, 0);
                check("mid_rst_valid", bus.Valid, 0);
                check("mid_rst_par_err", bus.ParErr, 0);
                check("mid_rst_frame_err", bus.FrameErr, 0);
                check("mid_rst_busy", bus.Busy, 0);
            end
        join
        repeat (10) @(negedge Clock);
        Rst = 1'b1;
        repeat (10) @(negedge Clock);
        send_frame(8'h81, 0, 0, 0, 1, 20, 1, 0, -1);

        // Back-to-back frames.
        send_frame(8'h12, 0, 0, 0, 1, 0, 1, 0, -1);
        send_frame(8'h34, 0, 0, 0, 1, 20, 1, 0, -1);

`ifdef RX_MAJORITY_EN
        send_frame(8'hC3, 0, 0, 0, 1, 20, 1, 0, 2);
`endif

        // Random frames with mid-frame configuration changes.
        for (int k = 0; k < 6; k++) begin
            logic [7:0] d;
            logic       pen, p, pbit, stop;
            int         gap;
            d    = 8'($urandom);
            pen  = 1'($urandom);
            p    = 1'($urandom);
            pbit = 1'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            gap  = stop ? $urandom_range(0, 30) : $urandom_range(5, 30);
            send_frame(d, pen, p, pbit, stop, gap, 1, 1, -1);
        end

        for (int w = 0; w < 3000 && exp_q.size() != 0; w++) @(negedge Clock);
        check("frames_pending", 32'(exp_q.size()), 0);
        check("valid_count", n_valid, n_sent);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_uart.md
Name: rx_uart

Overview:
- Serial receiver on the downstream side of the UART transmit path; consumes the line driven by the transmitter's serial output.
- Frame format: start bit, 8 data bits LSB first, optional parity bit, 1 stop bit.
- Frames are recovered with 16x oversampling at a rate chosen by the same 3-bit baud select used by the transmitter.
- Each frame is presented as a byte with a one-cycle valid strobe, plus parity and framing status.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- OVERSAMPLE, 16, ticks per bit. Fixed at 16; any other value is unsupported.

Ports:
- Clock  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- RxIn  in  1  serial line; idles high.
- BaudSel  in  3  rate select: 0..7 = 1200, 2400, 4800, 9600, 19200, 38400, 57600, 115200 baud.
- ParEn  in  1  1 = parity bit expected after the data bits.
- Par  in  1  0 = even parity, 1 = odd parity.
- DataOut  out  8  last received byte.
- Valid  out  1  one-cycle strobe: new byte and status available.
- ParErr  out  1  parity mismatch for the byte flagged by Valid.
- FrameErr  out  1  stop bit sampled low for the byte flagged by Valid.
- Busy  out  1  high while a frame is being received.

Behaviour:
- Reset (Rst=0, asynchronous): FSM goes to IDLE, counters clear, synchroniser flops load 1. Outputs reset to DataOut=0, Valid=0, ParErr=0, FrameErr=0, Busy=0.
- Synchroniser: RxIn passes through a 2-flop synchroniser; all logic uses the synchronised value `rxs`.
- Edge detect: a falling edge is rxs_prev=1 and rxs=0.
- Tick generator: divisor DIV = round(CLK_HZ/(baud*16)). Tick is a one-Clock pulse every DIV clocks. The divider restarts on the start edge so tick phase aligns to the frame.
- Latching: BaudSel, ParEn and Par are latched on leaving IDLE. Changes mid-frame are ignored until the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP. A 4-bit tick counter `tc` and a 3-bit bit index are used.
- IDLE: on a falling edge, go to START with tc=0. A line held low does not retrigger, because an edge is required.
- START: at tc=7 (mid-bit), if rxs=1 it is a false start: return to IDLE with no Valid. Otherwise clear tc and go to DATA.
- DATA:
  - Sample at every tc=15 (i.e. at bit centre) and shift into bit[7] of the shift register, shifting right.
  - After 8 samples, go to PARITY if ParEn=1, else STOP.
- PARITY: sample at tc=15.
  - Error if XOR(data, parity bit) != Par.
  - In other words, even parity requires the total count of ones to be even; odd parity requires it to be odd.
- STOP: sample at tc=15. FrameErr_next = (sample==0). In the following cycle:
  - DataOut, ParErr and FrameErr update together.
  - Valid pulses for exactly 1 Clock.
  - FSM returns to IDLE.
- Status holding: DataOut, ParErr and FrameErr hold until the next Valid. ParErr is 0 when ParEn=0.
- Busy: 1 from the cycle after the start edge until the cycle Valid asserts. Busy drops on a false start.
- Latency: Valid asserts 2 (synchroniser) + 1 cycles after the stop-bit centre sample. Returning to IDLE at mid-stop-bit leaves half a bit of margin for resync.
- Back-to-back frames (next start bit immediately after stop) must be received with no loss.
- Break handling: a line held low through a frame gives DataOut=0x00, FrameErr=1, then no further frame until the line goes high and falls again.
- Reset mid-frame aborts the frame; no Valid is generated for it.

Optional Feature:
- Macro RX_MAJORITY_EN.
- When defined: each bit value, including the START check, is the 2-of-3 majority of rxs at tc=6, 7, 8, with the decision taken at tc=8. All later state timing is unchanged.
- When undefined: a single sample at tc=7 is used; no vote logic is built.

Decomposition:
- Package uart_pkg contains:
  - OVERSAMPLE constant;
  - `baud_sel_t` (3-bit) typedef;
  - the baud rate table;
  - constant function div_for(CLK_HZ, sel);
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
- One sub-module: uart_baud_tick (divider with restart input, tick output). It is also reusable by the transmit path.

Test Plan (CLK_HZ=50 MHz, BaudSel=7, DIV=27, bit = 432 clocks):
- Frame 0xA5, ParEn=0 -> single Valid pulse, DataOut=0xA5, ParErr=0, FrameErr=0, Busy low after Valid.
- Frame 0x3C, ParEn=1, Par=0, parity bit 0 -> ParErr=0. Repeat with parity bit 1 -> ParErr=1, DataOut=0x3C.
- Frame 0x55 with stop bit driven 0 -> FrameErr=1. The next frame 0x0F with good stop -> FrameErr=0, DataOut=0x0F.
- RxIn low for 100 clocks, then high -> no Valid, Busy pulses then returns to 0, and a following frame 0x81 is received correctly.
- Rst asserted during data bit 4 -> all outputs 0 immediately. After release, frame 0x81 gives Valid with DataOut=0x81.
- Frames 0x12 and 0x34 back-to-back -> two Valid pulses with the correct bytes. With RX_MAJORITY_EN, a 1-clock glitch at a bit centre does not corrupt the byte.
